// File: rtl/crc32_serial.sv
// crc32_serial
// Bit-serial CRC-32/MPEG-2 generator (normal polynomial form, no reflection,
// no final XOR). A frame is opened by a load pulse in IDLE, the message is
// streamed in MSB-first during CALC and echoed on crc_out one cycle later.
// It is closed by a d_finish pulse, after which the 32 CRC bits are shifted
// out MSB first during SEND. The block then returns to IDLE.
//
// Stream protocol: there is no valid/ready handshake. While in CALC every
// clock cycle carries one message bit on crc_in. The output is a fixed-latency
// registered stream: message echo, one 0 bit on the d_finish cycle, then
// 32 CRC bits, then 0 while idle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   load       start-of-frame pulse, only acted on in IDLE
//   d_finish   end-of-message pulse, only acted on in CALC
//   crc_in     serial message bit
//   crc_out    registered serial output (echo, then CRC)
//   fsm_state  current FSM state for observation (0=IDLE, 1=CALC, 2=SEND)
module crc32_serial #(
   parameter logic [31:0] POLY = 32'h04C11DB7,
   parameter logic [31:0] INIT = 32'hFFFFFFFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       d_finish,
   input  logic       crc_in,
   output logic       crc_out,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] crc_reg;
   logic [4:0]  cnt;

   logic        fb;
   logic [31:0] crc_next;

   // One step of the shift-register division for the incoming bit.
   always_comb begin
      fb       = crc_reg[31] ^ crc_in;
      crc_next = {crc_reg[30:0], 1'b0} ^ (fb ? POLY : 32'h0000_0000);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         crc_reg <= INIT;
         cnt     <= 5'd0;
         crc_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               crc_out <= 1'b0;
               // load takes priority over a coincident d_finish, which is
               // meaningless here anyway.
               if (load) begin
                  crc_reg <= INIT;
                  state   <= CALC;
               end
            end
            CALC: begin
               if (d_finish) begin
                  // The bit present on the d_finish cycle is not part of
                  // the message.
                  state   <= SEND;
                  cnt     <= 5'd0;
                  crc_out <= 1'b0;
               end else begin
                  crc_reg <= crc_next;
                  crc_out <= crc_in;
               end
            end
            SEND: begin
               crc_out <= crc_reg[5'd31 - cnt];
               // The counter wraps from 31 back to 0 exactly as the frame
               // ends, so IDLE always starts with a cleared counter.
               cnt     <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               crc_out <= 1'b0;
            end
         endcase
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_crc32_serial.sv
// Testbench for crc32_serial. Stimulus tasks push the expected
// {state, crc_out} for every driven cycle into exp_q; an independent monitor
// pops one entry per clock and compares it with the DUT outputs.
module tb_crc32_serial;

   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] INIT = 32'hFFFFFFFF;
   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_CALC = 2'd1;
   localparam logic [1:0]  S_SEND = 2'd2;
   localparam int          W = 3;

   logic       clk;
   logic       rst;
   logic       load;
   logic       d_finish;
   logic       crc_in;
   logic       crc_out;
   logic [1:0] fsm_state;

   logic [W-1:0] exp_q[$];
   bit           msg_q[$];

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   int frame_cyc;
   int abort_at;
   bit aborted;

   crc32_serial #(
      .POLY(POLY),
      .INIT(INIT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .d_finish (d_finish),
      .crc_in   (crc_in),
      .crc_out  (crc_out),
      .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      rst      = 1'b0;
      load     = 1'b0;
      d_finish = 1'b0;
      crc_in   = 1'b0;
   end

   // ---------------- reference model ----------------
   // CRC as polynomial remainder: (INIT * x^n + M(x) * x^32) mod P, computed
   // by long division over an explicit bit array (index 0 = highest degree).
   function automatic logic [31:0] crc_model();
      bit          a[$];
      logic [32:0] p33;
      logic [31:0] r;
      int          n;
      n   = msg_q.size();
      p33 = {1'b1, POLY};
      a   = msg_q;
      for (int i = 0; i < 32; i++) a.push_back(1'b0);
      for (int i = 0; i < 32; i++) a[i] = a[i] ^ INIT[31-i];
      for (int i = 0; i < n; i++) begin
         if (a[i]) begin
            for (int j = 0; j <= 32; j++) a[i+j] = a[i+j] ^ p33[32-j];
         end
      end
      for (int j = 0; j < 32; j++) r[31-j] = a[n+j];
      return r;
   endfunction

   task automatic load_string(input string s);
      byte c;
      msg_q.delete();
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         for (int b = 7; b >= 0; b--) msg_q.push_back(c[b]);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input bit r, input bit l, input bit f, input bit b,
                        input logic [W-1:0] e);
      @(negedge clk);
      rst      = r;
      load     = l;
      d_finish = f;
      crc_in   = b;
      exp_q.push_back(e);
   endtask

   task automatic idle_cycles(input int n, input bit noisy);
      for (int i = 0; i < n; i++)
         drive(1'b1, 1'b0, noisy ? 1'($urandom_range(0, 1)) : 1'b0,
               1'($urandom_range(0, 1)), {S_IDLE, 1'b0});
   endtask

   // One frame step; at cycle abort_at of the frame a reset is applied
   // instead and the rest of the frame is dropped.
   task automatic fstep(input bit l, input bit f, input bit b,
                        input logic [W-1:0] e);
      if (aborted) return;
      if (frame_cyc == abort_at) begin
         drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), {S_IDLE, 1'b0});
         aborted = 1'b1;
      end else begin
         drive(1'b1, l, f, b, e);
      end
      frame_cyc++;
   endtask

   // Sends msg_q as one frame and expects exp_crc. When noisy, load and
   // d_finish are toggled wherever they must be ignored.
   task automatic run_frame(input logic [31:0] exp_crc, input bit noisy,
                            input int abort_cycle);
      frame_cyc = 0;
      abort_at  = abort_cycle;
      aborted   = 1'b0;
      fstep(1'b1, noisy ? 1'($urandom_range(0, 1)) : 1'b0,
            1'($urandom_range(0, 1)), {S_CALC, 1'b0});
      foreach (msg_q[i])
         fstep(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, msg_q[i],
               {S_CALC, msg_q[i]});
      fstep(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1,
            1'($urandom_range(0, 1)), {S_SEND, 1'b0});
      for (int k = 0; k < 32; k++)
         fstep(noisy ? 1'($urandom_range(0, 1)) : 1'b0,
               noisy ? 1'($urandom_range(0, 1)) : 1'b0,
               1'($urandom_range(0, 1)),
               {(k == 31) ? S_IDLE : S_SEND, exp_crc[31-k]});
      // After completion or abort the block must sit quietly in IDLE.
      idle_cycles(3, noisy);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (fsm_state !== e[2:1]) begin
               errors++;
               $display("FAIL state cycle=%0d got=%0d exp=%0d", cycle, fsm_state, e[2:1]);
            end
            checks++;
            if (crc_out !== e[0]) begin
               errors++;
               $display("FAIL crc_out cycle=%0d got=%b exp=%b", cycle, crc_out, e[0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int len;
      // Reset state, then stay in IDLE without load (d_finish ignored).
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), {S_IDLE, 1'b0});
      idle_cycles(4, 1'b1);

      // Check value.
      load_string("123456789");
      run_frame(32'h0376E6E7, 1'b0, -1);

      // Single-bit messages.
      msg_q.delete(); msg_q.push_back(1'b1);
      run_frame(32'hFFFFFFFE, 1'b0, -1);
      msg_q.delete(); msg_q.push_back(1'b0);
      run_frame(32'hFB3EE249, 1'b0, -1);

      // Zero-length message: INIT is sent unchanged.
      msg_q.delete();
      run_frame(INIT, 1'b0, -1);

      // Alternating stream, toggling every two cycles for 80 cycles.
      msg_q.delete();
      for (int i = 0; i < 80; i++) msg_q.push_back(((i / 2) % 2) == 0);
      run_frame(crc_model(), 1'b0, -1);

      // Reset mid-SEND at k=10, then a fresh check-value frame.
      load_string("123456789");
      run_frame(32'h0376E6E7, 1'b0, 1 + 72 + 1 + 10);
      load_string("123456789");
      run_frame(32'h0376E6E7, 1'b0, -1);

      // Reset mid-CALC.
      load_string("123456789");
      run_frame(32'h0376E6E7, 1'b0, 20);

      // Check value again with load/d_finish noise where they are ignored.
      load_string("123456789");
      run_frame(32'h0376E6E7, 1'b1, -1);

      // Random messages, some with noise.
      for (int f = 0; f < 12; f++) begin
         len = $urandom_range(0, 100);
         msg_q.delete();
         for (int i = 0; i < len; i++) msg_q.push_back(1'($urandom_range(0, 1)));
         run_frame(crc_model(), 1'(f % 2), -1);
         idle_cycles($urandom_range(0, 3), 1'b1);
      end

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/crc32_serial.md
CRC32_SERIAL -- requirements
Module: crc32_serial

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-low reset; sampled only on the clk rising edge.
REQ-004 load  input  1  start-of-message pulse; recognised only in IDLE.
REQ-005 d_finish  input  1  end-of-message pulse; recognised only in CALC.
REQ-006 crc_in  input  1  serial message bit, MSB of each byte first.
REQ-007 crc_out  output  1  registered serial output: message bits, then 32 CRC bits.
REQ-008 Parameter POLY, default 32'h04C11DB7: CRC-32 generator polynomial, normal (non-reflected) form.
REQ-009 Parameter INIT, default 32'hFFFFFFFF: CRC register preset value.

Function
REQ-010 The block SHALL implement a 3-state FSM: IDLE, CALC, SEND.
REQ-011 IDLE: on a cycle with load=1, the block SHALL preset crc_reg to INIT and move to CALC; crc_in is not absorbed on that cycle; d_finish is ignored.
REQ-012 CALC, d_finish=0: the block SHALL absorb crc_in with fb = crc_reg[31]^crc_in and crc_reg <= {crc_reg[30:0],1'b0} ^ (fb ? POLY : 0).
REQ-013 CALC: the block SHALL register crc_out <= crc_in (message pass-through, 1-cycle latency).
REQ-014 CALC, d_finish=1: crc_in SHALL NOT be absorbed; the state SHALL move to SEND; the bit counter SHALL clear to 0; crc_out SHALL be 0 on that cycle.
REQ-015 SEND: for 32 consecutive cycles, crc_out SHALL be crc_reg[31-k] for k=0..31, MSB first, with 1-cycle registered latency.
REQ-016 The final CRC SHALL use no reflection and no final XOR (CRC-32/MPEG-2).
REQ-017 After the 32nd SEND cycle (counter=31), the block SHALL return to IDLE.
REQ-018 IDLE: crc_out SHALL be 0.
REQ-019 load SHALL be ignored in CALC and SEND (no restart).
REQ-020 d_finish SHALL be ignored in IDLE and SEND.
REQ-021 Simultaneous load=1 and d_finish=1 in IDLE: load SHALL win and the block moves to CALC.
REQ-022 Message length SHALL be unbounded; crc_reg updates every CALC cycle without wrap limit.
REQ-023 A zero-length message (d_finish on the first CALC cycle) SHALL send INIT unchanged.
REQ-024 The bit counter SHALL be 5 bits and SHALL wrap only at the SEND exit.

Reset
REQ-025 When rst=0 at a clk edge, the block SHALL set state=IDLE, crc_reg=INIT, counter=0, crc_out=0, regardless of state.
REQ-026 Reset mid-CALC or mid-SEND SHALL abort the frame; no partial CRC SHALL be output afterwards.
REQ-027 After reset release, the block SHALL stay in IDLE until load is sampled high.

Verification
REQ-028 Check value: load pulse, then the 72 bits of ASCII "123456789" (MSB first), then d_finish pulse -> crc_out echoes the 72 bits with 1-cycle delay, then emits 32'h0376E6E7 MSB first, then returns to 0.
REQ-029 Single bit: load, crc_in=1 for one CALC cycle, d_finish -> CRC 32'hFFFFFFFE sent; with crc_in=0 instead -> 32'hFB3EE249.
REQ-030 Zero length: load, then d_finish on the next cycle -> 32 ones on crc_out, then 0 and IDLE.
REQ-031 Alternating stream: crc_in toggles every 2 cycles for 80 cycles after load, then d_finish -> crc_out equals the bit-accurate reference model (software CRC-32/MPEG-2 of the same bits) for all 32 CRC bits.
REQ-032 Reset mid-SEND at k=10 -> crc_out=0 the next cycle, state IDLE; a fresh "123456789" frame then yields 32'h0376E6E7.
REQ-033 load pulses during CALC and SEND, and d_finish pulses in IDLE/SEND -> no state or CRC change versus the undisturbed run.
